// File: rtl/rgb_fade_driver.sv
// PWM LED driver that fades between a current and a target color/level.
// On a color change it fades down to zero first, swaps color, then fades up.
module rgb_fade_driver #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                req,
    input  logic [2:0]          color_in,
    input  logic [PWM_BITS-1:0] level_in,
    output logic                busy,
    output logic [2:0]          rgb
);

    localparam int PS_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PWM_BITS-1:0] MAX_DUTY = {PWM_BITS{1'b1}};
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FADE_DOWN = 2'd1,
        FADE_UP   = 2'd2
    } state_t;

    state_t              state;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_act;
    logic [PS_W-1:0]     presc;
    logic [2:0]          color_cur;
    logic [2:0]          color_tgt;
    logic [PWM_BITS-1:0] level_tgt;
    logic [2:0]          rgb_q;

    logic                step;
    logic [PWM_BITS-1:0] duty_dn;
    logic [PWM_BITS-1:0] duty_up;

    // Saturating neighbours of duty so it can never wrap.
    always_comb begin
        step    = (presc == PS_LAST);
        duty_dn = (duty != '0) ? duty - 1'b1 : duty;
        duty_up = (duty != MAX_DUTY) ? duty + 1'b1 : duty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pwm_cnt   <= '0;
            duty      <= '0;
            duty_act  <= '0;
            presc     <= '0;
            color_cur <= '0;
            color_tgt <= '0;
            level_tgt <= '0;
            rgb_q     <= '0;
        end else if (ena) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == MAX_DUTY)
                duty_act <= duty;
            rgb_q <= color_cur & {3{pwm_cnt < duty_act}};

            case (state)
                IDLE: begin
                    presc <= '0;
                    if (req) begin
                        color_tgt <= color_in;
                        level_tgt <= level_in;
                        if (color_in != color_cur) begin
                            if (duty != '0) begin
                                state <= FADE_DOWN;
                            end else begin
                                color_cur <= color_in;
                                if (level_in != '0)
                                    state <= FADE_UP;
                            end
                        end else if (level_in > duty) begin
                            state <= FADE_UP;
                        end else if (level_in < duty) begin
                            state <= FADE_DOWN;
                        end
                    end
                end

                FADE_DOWN: begin
                    if (step) begin
                        presc <= '0;
                        duty  <= duty_dn;
                        if (color_tgt != color_cur) begin
                            if (duty_dn == '0) begin
                                color_cur <= color_tgt;
                                state     <= (level_tgt != '0) ? FADE_UP : IDLE;
                            end
                        end else if (duty_dn <= level_tgt) begin
                            state <= IDLE;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end

                FADE_UP: begin
                    if (step) begin
                        presc <= '0;
                        duty  <= duty_up;
                        if (duty_up >= level_tgt || duty_up == MAX_DUTY)
                            state <= IDLE;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end else begin
            rgb_q <= '0;
        end
    end

    assign busy = (state != IDLE);
    assign rgb  = rgb_q;

endmodule
